// File: rtl/bitcoin_hash_pkg.sv
// Shared types and constants for the bitcoin hasher and its memory-side responder.
package bitcoin_hash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } mon_state_t;

  localparam int          NUM_NONCES       = 16;
  localparam logic [31:0] BEST_INIT        = 32'hFFFF_FFFF;
  localparam logic [31:0] OOR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  // Lower hash wins; on a tie the lower nonce index wins.
  function automatic logic is_better(input logic [31:0] data,
                                     input logic [3:0]  idx,
                                     input logic [31:0] best,
                                     input logic [3:0]  nonce);
    return (data < best) || ((data == best) && (idx < nonce));
  endfunction

endpackage

// File: rtl/bitcoin_mem_responder_if.sv
// Word-memory bus between the hasher (mem port) and the host preload/readback port.
interface bitcoin_mem_responder_if;

  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;

  modport master (
    output mem_addr, mem_we, mem_write_data,
    output host_we, host_addr, host_wdata,
    input  mem_read_data, host_rdata
  );

  modport slave (
    input  mem_addr, mem_we, mem_write_data,
    input  host_we, host_addr, host_wdata,
    output mem_read_data, host_rdata
  );

endinterface

// File: rtl/bitcoin_mem_responder_word_ram_dp.sv
// Two-port 32-bit word RAM with registered reads; the mem port wins same-address write collisions.
module word_ram_dp
  import bitcoin_hash_pkg::*;
#(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] OOR_DATA = OOR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic [15:0] host_addr,
  input  logic        host_we,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] ram [DEPTH];

  logic mem_in_range;
  logic host_in_range;
  logic mem_write_ok;
  logic host_write_ok;

  assign mem_in_range  = 32'(mem_addr) < DEPTH;
  assign host_in_range = 32'(host_addr) < DEPTH;
  assign mem_write_ok  = mem_we && mem_in_range;
  assign host_write_ok = host_we && host_in_range &&
                         !(mem_write_ok && (host_addr == mem_addr));

  always_ff @(posedge clk) begin
    if (mem_write_ok)
      ram[mem_addr[AW-1:0]] <= mem_wdata;
    if (host_write_ok)
      ram[host_addr[AW-1:0]] <= host_wdata;
  end

  // Reads sample the array before this edge's writes land, giving read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      mem_rdata  <= mem_in_range  ? ram[mem_addr[AW-1:0]]  : OOR_DATA;
      host_rdata <= host_in_range ? ram[host_addr[AW-1:0]] : OOR_DATA;
    end
  end

endmodule

// File: rtl/bitcoin_mem_responder.sv
// Memory-side responder for the hasher plus a capture monitor over the nonce result window.
module bitcoin_mem_responder
  import bitcoin_hash_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          OUT_WORDS = NUM_NONCES,
  parameter logic [31:0] OOR_DATA  = OOR_DATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  bitcoin_mem_responder_if.slave  bus,
  input  logic [15:0]             out_base,
  input  logic                    arm,
  output logic                    capture_done,
  output logic [4:0]              capture_count,
  output logic [31:0]             best_hash,
  output logic [3:0]              best_nonce,
  output logic                    addr_err
);

  word_ram_dp #(
    .DEPTH    (DEPTH),
    .OOR_DATA (OOR_DATA)
  ) u_ram (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (bus.mem_addr),
    .mem_we     (bus.mem_we),
    .mem_wdata  (bus.mem_write_data),
    .mem_rdata  (bus.mem_read_data),
    .host_addr  (bus.host_addr),
    .host_we    (bus.host_we),
    .host_wdata (bus.host_wdata),
    .host_rdata (bus.host_rdata)
  );

  mon_state_t            state;
  logic [15:0]           out_base_q;
  logic [OUT_WORDS-1:0]  written;

  logic [16:0] addr_ext;
  logic [16:0] base_ext;
  logic [16:0] win_end;
  logic        in_window;
  logic        mem_oor;
  logic [3:0]  idx;
  logic [4:0]  count_next;

  // 17-bit window bounds so a window near 16'hFFFF truncates instead of wrapping.
  assign addr_ext   = {1'b0, bus.mem_addr};
  assign base_ext   = {1'b0, out_base_q};
  assign win_end    = base_ext + 17'(OUT_WORDS);
  assign in_window  = (addr_ext >= base_ext) && (addr_ext < win_end);
  assign idx        = bus.mem_addr[3:0] - out_base_q[3:0];
  assign mem_oor    = 32'(bus.mem_addr) >= DEPTH;
  assign count_next = capture_count + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      out_base_q    <= '0;
      written       <= '0;
      capture_count <= '0;
      capture_done  <= 1'b0;
      best_hash     <= BEST_INIT;
      best_nonce    <= '0;
      addr_err      <= 1'b0;
    end else if (arm) begin
      state         <= ARMED;
      out_base_q    <= out_base;
      written       <= '0;
      capture_count <= '0;
      capture_done  <= 1'b0;
      best_hash     <= BEST_INIT;
      best_nonce    <= '0;
      addr_err      <= 1'b0;
    end else begin
      if (mem_oor)
        addr_err <= 1'b1;
      case (state)
        ARMED, CAPTURE: begin
          if (bus.mem_we && in_window) begin
            if (is_better(bus.mem_write_data, idx, best_hash, best_nonce)) begin
              best_hash  <= bus.mem_write_data;
              best_nonce <= idx;
            end
            // Only the first write to each index counts toward completion.
            if (!written[idx]) begin
              written[idx]  <= 1'b1;
              capture_count <= count_next;
              if (count_next == 5'(OUT_WORDS)) begin
                state        <= DONE;
                capture_done <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end else begin
              state <= CAPTURE;
            end
          end
        end
        DONE:    state <= DONE;
        IDLE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// Directed bench for bitcoin_mem_responder: read latency, capture, ties, collisions, arm and reset.
module tb_bitcoin_mem_responder;
  import bitcoin_hash_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] out_base;
  logic        arm;
  logic        capture_done;
  logic [4:0]  capture_count;
  logic [31:0] best_hash;
  logic [3:0]  best_nonce;
  logic        addr_err;

  int tests_run    = 0;
  int tests_failed = 0;

  bitcoin_mem_responder_if bus ();

  bitcoin_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .out_base      (out_base),
    .arm           (arm),
    .capture_done  (capture_done),
    .capture_count (capture_count),
    .best_hash     (best_hash),
    .best_nonce    (best_nonce),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one cycle of inputs, then releases the strobes; returns 1ns after the edge.
  task automatic applyStimulus(input logic m_we, input logic [15:0] m_addr, input logic [31:0] m_data,
                               input logic h_we, input logic [15:0] h_addr, input logic [31:0] h_data,
                               input logic do_arm, input logic [15:0] base);
    bus.mem_we         = m_we;
    bus.mem_addr       = m_addr;
    bus.mem_write_data = m_data;
    bus.host_we        = h_we;
    bus.host_addr      = h_addr;
    bus.host_wdata     = h_data;
    arm                = do_arm;
    out_base           = base;
    @(posedge clk);
    #1;
    bus.mem_we  = 1'b0;
    bus.host_we = 1'b0;
    arm         = 1'b0;
  endtask

  task automatic memWrite(input logic [15:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 16'h0, 32'h0, 1'b0, out_base);
  endtask

  task automatic doArm(input logic [15:0] base);
    applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 32'h0, 1'b1, base);
  endtask

  initial begin
    bus.mem_we         = 1'b0;
    bus.mem_addr       = 16'h0;
    bus.mem_write_data = 32'h0;
    bus.host_we        = 1'b0;
    bus.host_addr      = 16'h0;
    bus.host_wdata     = 32'h0;
    arm                = 1'b0;
    out_base           = 16'h0;
    reset              = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_rdata",  bus.mem_read_data, 32'h0);
    checkOutput("rst_host_rdata", bus.host_rdata, 32'h0);
    checkOutput("rst_count",      32'(capture_count), 32'h0);
    checkOutput("rst_done",       32'(capture_done), 32'h0);
    checkOutput("rst_err",        32'(addr_err), 32'h0);
    checkOutput("rst_best",       best_hash, 32'hFFFF_FFFF);
    checkOutput("rst_nonce",      32'(best_nonce), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 16'h0, 32'h0, 1'b1, 16'(i), 32'h1000 + 32'(i), 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 16'(i), 32'h0, 1'b0, 16'(19 - i), 32'h0, 1'b0, 16'h0);
      checkOutput($sformatf("lat_mem_%0d", i),  bus.mem_read_data, 32'h1000 + 32'(i));
      checkOutput($sformatf("lat_host_%0d", i), bus.host_rdata, 32'h1000 + 32'(19 - i));
    end
    memWrite(16'h0005, 32'h0000_CAFE);
    checkOutput("rbw_old", bus.mem_read_data, 32'h0000_1005);
    applyStimulus(1'b0, 16'h0005, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
    checkOutput("rbw_new", bus.mem_read_data, 32'h0000_CAFE);

    doArm(16'h0100);
    checkOutput("arm_count", 32'(capture_count), 32'h0);
    for (int i = 0; i < 16; i++) begin
      memWrite(16'h0100 + 16'(i), 32'h8000_0000 - 32'(i));
      if (i == 14) begin
        checkOutput("cap15_count", 32'(capture_count), 32'd15);
        checkOutput("cap15_done",  32'(capture_done), 32'h0);
      end
    end
    checkOutput("cap_count", 32'(capture_count), 32'd16);
    checkOutput("cap_done",  32'(capture_done), 32'h1);
    checkOutput("cap_best",  best_hash, 32'h7FFF_FFF1);
    checkOutput("cap_nonce", 32'(best_nonce), 32'd15);
    memWrite(16'h0100, 32'h0);
    checkOutput("done_hold",  32'(capture_done), 32'h1);
    checkOutput("done_best",  best_hash, 32'h7FFF_FFF1);

    doArm(16'h0100);
    checkOutput("rearm_done",  32'(capture_done), 32'h0);
    checkOutput("rearm_best",  best_hash, 32'hFFFF_FFFF);
    checkOutput("rearm_count", 32'(capture_count), 32'h0);
    memWrite(16'h0103, 32'd5);
    memWrite(16'h0103, 32'd5);
    memWrite(16'h0101, 32'd5);
    checkOutput("dup_count", 32'(capture_count), 32'd2);
    checkOutput("dup_best",  best_hash, 32'd5);
    checkOutput("dup_nonce", 32'(best_nonce), 32'd1);

    applyStimulus(1'b1, 16'h0020, 32'h0000_BBBB, 1'b1, 16'h0020, 32'h0000_AAAA, 1'b0, 16'h0100);
    applyStimulus(1'b0, 16'h0020, 32'h0, 1'b0, 16'h0020, 32'h0, 1'b0, 16'h0100);
    checkOutput("coll_host", bus.host_rdata, 32'h0000_BBBB);
    checkOutput("coll_mem",  bus.mem_read_data, 32'h0000_BBBB);
    applyStimulus(1'b1, 16'h0021, 32'h0000_1111, 1'b1, 16'h0022, 32'h0000_2222, 1'b0, 16'h0100);
    applyStimulus(1'b0, 16'h0021, 32'h0, 1'b0, 16'h0022, 32'h0, 1'b0, 16'h0100);
    checkOutput("dual_mem",  bus.mem_read_data, 32'h0000_1111);
    checkOutput("dual_host", bus.host_rdata, 32'h0000_2222);
    applyStimulus(1'b0, 16'h0, 32'h0, 1'b1, 16'h03FF, 32'h003F_F3FF, 1'b0, 16'h0100);
    applyStimulus(1'b0, 16'h03FF, 32'h0, 1'b0, 16'hFFFF, 32'h0, 1'b0, 16'h0100);
    checkOutput("last_word", bus.mem_read_data, 32'h003F_F3FF);
    checkOutput("host_oor",  bus.host_rdata, 32'hDEAD_BEEF);
    checkOutput("err_clear", 32'(addr_err), 32'h0);
    memWrite(16'h0400, 32'h1234_5678);
    checkOutput("oor_rdata", bus.mem_read_data, 32'hDEAD_BEEF);
    checkOutput("oor_err",   32'(addr_err), 32'h1);
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0100);
    checkOutput("oor_no_alias", bus.mem_read_data, 32'h0000_1000);
    checkOutput("err_sticky",   32'(addr_err), 32'h1);

    applyStimulus(1'b1, 16'h0200, 32'h1, 1'b0, 16'h0, 32'h0, 1'b1, 16'h0200);
    checkOutput("armwr_count", 32'(capture_count), 32'h0);
    checkOutput("armwr_best",  best_hash, 32'hFFFF_FFFF);
    checkOutput("armwr_err",   32'(addr_err), 32'h0);
    applyStimulus(1'b0, 16'h0200, 32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0200);
    checkOutput("armwr_ram", bus.mem_read_data, 32'h1);
    memWrite(16'h0205, 32'd9);
    checkOutput("win_count", 32'(capture_count), 32'd1);
    checkOutput("win_nonce", 32'(best_nonce), 32'd5);
    memWrite(16'h0210, 32'h0);
    memWrite(16'h01FF, 32'h0);
    checkOutput("edge_count", 32'(capture_count), 32'd1);
    checkOutput("edge_best",  best_hash, 32'd9);

    doArm(16'h0300);
    for (int i = 0; i < 7; i++)
      memWrite(16'h0300 + 16'(i), 32'h100 + 32'(i));
    checkOutput("mid_count", 32'(capture_count), 32'd7);
    checkOutput("mid_best",  best_hash, 32'h100);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_count", 32'(capture_count), 32'h0);
    checkOutput("arst_best",  best_hash, 32'hFFFF_FFFF);
    checkOutput("arst_nonce", 32'(best_nonce), 32'h0);
    checkOutput("arst_rdata", bus.mem_read_data, 32'h0);
    checkOutput("arst_host",  bus.host_rdata, 32'h0);
    checkOutput("arst_done",  32'(capture_done), 32'h0);
    #2 reset = 1'b0;
    memWrite(16'h0307, 32'h1);
    checkOutput("idle_count", 32'(capture_count), 32'h0);
    checkOutput("idle_best",  best_hash, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
